timer_irq: RTL

Memory-mapped down-counting timer that generates the CPU's `int_timer` interrupt request and replaces the manually driven stimulus on that input. It sits on the peripheral bus beside the GPIO (button/switch/LED) and UART blocks, and is programmed by the pipelined core through load/store accesses. Its output feeds the core's interrupt input directly. It supports a programmable prescaler, one-shot or periodic mode, and a sticky pending flag that software clears with write-1-to-clear.

---
 rtl/timer_pkg.sv | 19 +
 rtl/timer_prescaler.sv | 35 +++
 rtl/timer_irq.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared register map and bit positions for the timer_irq peripheral.
package timer_pkg;

  // Byte offsets of the four software-visible registers.
  localparam logic [3:0] TMR_CTRL   = 4'h0;
  localparam logic [3:0] TMR_LOAD   = 4'h4;
  localparam logic [3:0] TMR_COUNT  = 4'h8;
  localparam logic [3:0] TMR_STATUS = 4'hC;

  // CTRL field positions; PRESC occupies CTRL[31:16].
  localparam int EN_BIT     = 0;
  localparam int RELOAD_BIT = 1;
  localparam int IE_BIT     = 2;
  localparam int PRESC_LSB  = 16;

  // STATUS field positions.
  localparam int PEND_BIT = 0;

endpackage

// File: rtl/timer_prescaler.sv
// Divides the clock into one-cycle ticks: one tick every (presc+1) enabled cycles.
module timer_prescaler #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [PW-1:0] presc,
  output logic          tick
);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign tick = en && (pcnt_q == presc);

  // Next prescale count: restart on a tick, hold at 0 while stopped or cleared.
  always_comb begin
    pcnt_d = pcnt_q + PW'(1);
    if (clr || !en || tick) begin
      pcnt_d = '0;
    end
  end

  // Prescale counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/timer_irq.sv
// Memory-mapped down-counting timer driving the core's int_timer request.
module timer_irq
  import timer_pkg::*;
#(
  parameter int DW = 32,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sel,
  input  logic          we,
  input  logic [3:0]    addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          int_timer
);

  logic          en_q, en_d;
  logic          reload_q, reload_d;
  logic          ie_q, ie_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] load_q, load_d;
  logic [DW-1:0] count_q, count_d;
  logic          pend_q, pend_d;
  logic          irq_q, irq_d;

  logic wr_ctrl, wr_load, wr_count, wr_status;
  logic en_rise, tick, expiry;

  assign wr_ctrl   = sel && we && (addr == TMR_CTRL);
  assign wr_load   = sel && we && (addr == TMR_LOAD);
  assign wr_count  = sel && we && (addr == TMR_COUNT);
  assign wr_status = sel && we && (addr == TMR_STATUS);

  // Software turning the timer on restarts both the count and the prescaler.
  assign en_rise = wr_ctrl && wdata[EN_BIT] && !en_q;

  // A software COUNT write on the same edge overrides the tick, so no expiry.
  assign expiry = tick && (count_q == '0) && !wr_count;

  timer_prescaler #(.PW(PW)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_q),
    .clr   (en_rise),
    .presc (presc_q),
    .tick  (tick)
  );

  // Next-state for registers, counter and pending flag; software writes take priority.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    en_d     = en_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    presc_d  = presc_q;
    load_d   = load_q;
    count_d  = count_q;
    pend_d   = pend_q;
    // IE sampled from the current register: a same-edge IE write cannot mask this expiry.
    irq_d    = expiry && ie_q;

    // W1C is applied before expiry so a simultaneous set wins.
    if (wr_status && wdata[PEND_BIT]) begin
      pend_d = 1'b0;
    end

    if (tick && (count_q != '0)) begin
      count_d = count_q - DW'(1);
    end

    if (expiry) begin
      pend_d = 1'b1;
      if (reload_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end

    // Software register writes override the hardware updates above.
    if (wr_ctrl) begin
      en_d     = wdata[EN_BIT];
      reload_d = wdata[RELOAD_BIT];
      ie_d     = wdata[IE_BIT];
      presc_d  = wdata[PRESC_LSB +: PW];
      if (en_rise) begin
        count_d = load_q;
      end
    end

    if (wr_load) begin
      load_d = wdata;
    end

    if (wr_count) begin
      count_d = wdata;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      presc_q  <= '0;
      load_q   <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      presc_q  <= presc_d;
      load_q   <= load_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
    end
  end

  // Zero-latency read mux; unselected or unmapped accesses return 0.
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        TMR_CTRL: begin
          rdata[EN_BIT]             = en_q;
          rdata[RELOAD_BIT]         = reload_q;
          rdata[IE_BIT]             = ie_q;
          rdata[PRESC_LSB +: PW]    = presc_q;
        end
        TMR_LOAD:   rdata = load_q;
        TMR_COUNT:  rdata = count_q;
        TMR_STATUS: rdata[PEND_BIT] = pend_q;
        default:    rdata = '0;
      endcase
    end
  end

  assign int_timer = irq_q;

endmodule
